// File: rtl/pc_flow_if.sv
// Control-flow bundle between the decode/read stage and the PC unit.
// The master drives branch/jump requests; the slave returns PC and RAS status.
interface pc_flow_if #(
  parameter int XLEN      = 19,
  parameter int BIMM_W    = 8,
  parameter int JIMM_W    = 14,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic [2:0]        cf_op;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [BIMM_W-1:0] bimm;
  logic [JIMM_W-1:0] jimm;

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic              redirect;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_full;
  logic              ras_empty;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output stall, cf_op, rs1_data, rs2_data, bimm, jimm,
    input  pc, pc_next, redirect, ras_count, ras_full, ras_empty,
           ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, cf_op, rs1_data, rs2_data, bimm, jimm,
    output pc, pc_next, redirect, ras_count, ras_full, ras_empty,
           ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_flow_unit.sv
// Program counter and control-flow unit: next-PC selection for branches, jumps,
// calls and returns, with a circular hardware return-address stack.
module pc_flow_unit #(
  parameter int              XLEN      = 19,
  parameter int              BIMM_W    = 8,
  parameter int              JIMM_W    = 14,
  parameter int              RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic      clk,
  input  logic      rst,
  pc_flow_if.slave  bus
);

  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = SP_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    CF_NONE = 3'd0,
    CF_BEQ  = 3'd1,
    CF_BNE  = 3'd2,
    CF_JMP  = 3'd3,
    CF_CALL = 3'd4,
    CF_RET  = 3'd5
  } cf_op_e;

  logic [XLEN-1:0]  pc_q,    pc_d;
  logic [SP_W-1:0]  sp_q,    sp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q,   ovf_d;
  logic             unf_q,   unf_d;

  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic             ras_we;

  cf_op_e           op;
  logic [XLEN-1:0]  pc_inc;
  logic [XLEN-1:0]  bimm_ext;
  logic [XLEN-1:0]  jimm_ext;
  logic [XLEN-1:0]  ras_top;
  logic             operands_eq;
  logic             ras_is_full;
  logic             ras_is_empty;

  logic [XLEN-1:0]  pc_next_c;
  logic             redirect_c;
  logic             push_c;
  logic             pop_c;
  logic             underflow_c;

  assign op           = cf_op_e'(bus.cf_op);
  assign pc_inc       = pc_q + XLEN'(1);
  assign bimm_ext     = XLEN'($signed(bus.bimm));
  assign jimm_ext     = XLEN'(bus.jimm);
  assign ras_top      = ras_q[sp_q - SP_W'(1)];
  assign operands_eq  = (bus.rs1_data == bus.rs2_data);
  assign ras_is_full  = (count_q == CNT_FULL);
  assign ras_is_empty = (count_q == '0);

  // Next-PC selection; independent of stall so the fetch side can look ahead.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a latch.
    pc_next_c   = pc_inc;
    redirect_c  = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    underflow_c = 1'b0;
    unique case (op)
      CF_BEQ: begin
        if (operands_eq) begin
          pc_next_c  = pc_q + bimm_ext;
          redirect_c = 1'b1;
        end
      end
      CF_BNE: begin
        if (!operands_eq) begin
          pc_next_c  = pc_q + bimm_ext;
          redirect_c = 1'b1;
        end
      end
      CF_JMP: begin
        pc_next_c  = jimm_ext;
        redirect_c = 1'b1;
      end
      CF_CALL: begin
        pc_next_c  = jimm_ext;
        redirect_c = 1'b1;
        push_c     = 1'b1;
      end
      CF_RET: begin
        if (!ras_is_empty) begin
          pc_next_c  = ras_top;
          redirect_c = 1'b1;
          pop_c      = 1'b1;
        end else begin
          underflow_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Architectural state update; stall freezes everything.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!bus.stall) begin
      pc_d = pc_next_c;
      if (push_c) begin
        sp_d = sp_q + SP_W'(1);
        if (ras_is_full) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (pop_c) begin
        sp_d    = sp_q - SP_W'(1);
        count_d = count_q - CNT_W'(1);
      end
      if (underflow_c) begin
        unf_d = 1'b1;
      end
    end
  end

  // A push on a full stack overwrites the oldest entry, which is exactly slot[sp].
  assign ras_we = push_c && !bus.stall && !rst;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; count_q gates every read.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_q[sp_q] <= pc_inc;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_next       = pc_next_c;
  assign bus.redirect      = redirect_c;
  assign bus.ras_count     = count_q;
  assign bus.ras_full      = ras_is_full;
  assign bus.ras_empty     = ras_is_empty;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule
